// File: rtl/autotest_seq.sv
// autotest_seq: reads test vectors from SD blocks, runs them on a UUT and writes result blocks back.
// Build option: define AUTOTEST_CMP_EN to compare UUT outputs against expected bytes stored in each vector block.
// States: IDLE wait start | HRST host reset | HWAIT host ready | RD_HDR read count | RD_VEC load vector
//         RUN UUT running | WR_RES write result | NEXT advance k | DONE finished | ERR aborted by host error
module autotest_seq #(
    parameter int          IN_W     = 128,
    parameter int          OUT_W    = 64,
    parameter int          TIMEOUT  = 1000000,
    parameter logic [31:0] BASE_BLK = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             spi_rst,
    input  logic             spi_busy,
    input  logic             spi_err,
    output logic             spi_r_block,
    output logic             spi_r_byte,
    output logic             spi_w_block,
    output logic             spi_w_byte,
    output logic [31:0]      spi_block_addr,
    input  logic [7:0]       spi_data_out,
    output logic [7:0]       spi_data_in,
    output logic             rst_uut,
    input  logic             end_uut,
    output logic [IN_W-1:0]  input_to_uut,
    input  logic [OUT_W-1:0] output_from_uut,
    output logic             done,
    output logic             err,
    output logic [31:0]      vec_idx
);
    localparam logic [9:0]  IN_B  = 10'(IN_W / 8);
    localparam int          OUT_B = OUT_W / 8;
    localparam logic [31:0] TMO   = 32'(TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_HRST, S_HWAIT, S_RD_HDR, S_RD_VEC, S_RUN, S_WR_RES, S_NEXT, S_DONE, S_ERR
    } state_t;
    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT_HI, PH_WAIT_LO} phase_t;

    state_t             state_q;
    phase_t             ph_q;
    logic               blk_done_q;
    logic [9:0]         byte_q;
    logic [1:0]         hcnt_q;
    logic [31:0]        n_q, k_q, cyc_q;
    logic [7:0]         status_q;
    logic [OUT_W-1:0]   out_q;
    logic [IN_W-1:0]    in_q;
    logic               spi_rst_q, rst_uut_q, done_q, err_q;
    logic               r_block_q, r_byte_q, w_block_q, w_byte_q;
    logic [31:0]        addr_q;
    logic [7:0]         data_in_q;
    logic               mismatch;
    logic [511:0][7:0]  res_w;
    logic [7:0]         wr_data_d;

`ifdef AUTOTEST_CMP_EN
    localparam logic [9:0] EXP_END = 10'(IN_W / 8 + OUT_W / 8);
    logic [OUT_W-1:0] exp_q;
    logic [31:0]      fail_q;
    assign mismatch = (output_from_uut != exp_q);
`else
    assign mismatch = 1'b0;
`endif

    // Result block as a byte array; element 511 is byte 0 so byte b sits at index ~b.
    always_comb begin
        res_w = '0;
        res_w[511] = status_q;
        res_w[510:507] = cyc_q;
        res_w[506 -: OUT_B] = out_q;
`ifdef AUTOTEST_CMP_EN
        if (k_q == n_q - 32'd1) res_w[3:0] = fail_q;
`endif
        wr_data_d = res_w[~byte_q[8:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ph_q       <= PH_ISSUE;
            blk_done_q <= 1'b0;
            byte_q     <= '0;
            hcnt_q     <= '0;
            n_q        <= '0;
            k_q        <= '0;
            cyc_q      <= '0;
            status_q   <= '0;
            out_q      <= '0;
            in_q       <= '0;
            spi_rst_q  <= 1'b0;
            rst_uut_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            r_block_q  <= 1'b0;
            r_byte_q   <= 1'b0;
            w_block_q  <= 1'b0;
            w_byte_q   <= 1'b0;
            addr_q     <= '0;
            data_in_q  <= '0;
`ifdef AUTOTEST_CMP_EN
            exp_q      <= '0;
            fail_q     <= '0;
`endif
        end else begin
            r_block_q <= 1'b0;
            r_byte_q  <= 1'b0;
            w_block_q <= 1'b0;
            w_byte_q  <= 1'b0;
            if (spi_err && !(state_q inside {S_IDLE, S_DONE, S_ERR})) begin
                state_q   <= S_ERR;
                err_q     <= 1'b1;
                rst_uut_q <= 1'b1;
                spi_rst_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            state_q    <= S_HRST;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            spi_rst_q  <= 1'b1;
                            hcnt_q     <= 2'd3;
                            k_q        <= '0;
                            ph_q       <= PH_ISSUE;
                            blk_done_q <= 1'b0;
                            byte_q     <= '0;
`ifdef AUTOTEST_CMP_EN
                            fail_q     <= '0;
`endif
                        end
                    end
                    S_HRST: begin
                        if (hcnt_q == 2'd0) begin
                            spi_rst_q <= 1'b0;
                            state_q   <= S_HWAIT;
                        end else begin
                            hcnt_q <= hcnt_q - 2'd1;
                        end
                    end
                    S_HWAIT: begin
                        if (!spi_busy) begin
                            state_q <= S_RD_HDR;
                            addr_q  <= BASE_BLK;
                        end
                    end
                    S_RD_HDR, S_RD_VEC, S_WR_RES: begin
                        case (ph_q)
                            PH_ISSUE: begin
                                if (!spi_busy) begin
                                    if (!blk_done_q) begin
                                        r_block_q <= (state_q != S_WR_RES);
                                        w_block_q <= (state_q == S_WR_RES);
                                    end else begin
                                        r_byte_q <= (state_q != S_WR_RES);
                                        w_byte_q <= (state_q == S_WR_RES);
                                        if (state_q == S_WR_RES) data_in_q <= wr_data_d;
                                    end
                                    ph_q <= PH_WAIT_HI;
                                end
                            end
                            PH_WAIT_HI: if (spi_busy) ph_q <= PH_WAIT_LO;
                            default: begin
                                if (!spi_busy) begin
                                    ph_q <= PH_ISSUE;
                                    if (!blk_done_q) begin
                                        blk_done_q <= 1'b1;
                                    end else begin
                                        byte_q <= byte_q + 10'd1;
                                        if (state_q == S_RD_HDR && byte_q < 10'd4)
                                            n_q <= {n_q[23:0], spi_data_out};
                                        if (state_q == S_RD_VEC && byte_q < IN_B)
                                            in_q <= IN_W'({in_q, spi_data_out});
`ifdef AUTOTEST_CMP_EN
                                        if (state_q == S_RD_VEC && byte_q >= IN_B && byte_q < EXP_END)
                                            exp_q <= OUT_W'({exp_q, spi_data_out});
`endif
                                        if (byte_q == 10'd511) begin
                                            byte_q     <= '0;
                                            blk_done_q <= 1'b0;
                                            case (state_q)
                                                S_RD_HDR: begin
                                                    if (n_q == 32'd0) begin
                                                        state_q <= S_DONE;
                                                        done_q  <= 1'b1;
                                                    end else begin
                                                        state_q <= S_RD_VEC;
                                                        addr_q  <= BASE_BLK + 32'd1 + k_q;
                                                    end
                                                end
                                                S_RD_VEC: begin
                                                    state_q   <= S_RUN;
                                                    rst_uut_q <= 1'b0;
                                                    cyc_q     <= '0;
                                                end
                                                default: state_q <= S_NEXT;
                                            endcase
                                        end
                                    end
                                end
                            end
                        endcase
                    end
                    S_RUN: begin
                        // end_uut is tested first so it wins a tie with the timeout.
                        if (end_uut || cyc_q == TMO) begin
                            status_q  <= {6'd0, mismatch, ~end_uut};
                            out_q     <= output_from_uut;
                            rst_uut_q <= 1'b1;
                            state_q   <= S_WR_RES;
                            addr_q    <= BASE_BLK + 32'd1 + n_q + k_q;
`ifdef AUTOTEST_CMP_EN
                            if (mismatch) fail_q <= fail_q + 32'd1;
`endif
                        end else begin
                            cyc_q <= cyc_q + 32'd1;
                        end
                    end
                    S_NEXT: begin
                        k_q <= k_q + 32'd1;
                        if (k_q + 32'd1 == n_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD_VEC;
                            addr_q  <= BASE_BLK + 32'd2 + k_q;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign spi_rst        = spi_rst_q;
    assign spi_r_block    = r_block_q;
    assign spi_r_byte     = r_byte_q;
    assign spi_w_block    = w_block_q;
    assign spi_w_byte     = w_byte_q;
    assign spi_block_addr = addr_q;
    assign spi_data_in    = data_in_q;
    assign rst_uut        = rst_uut_q;
    assign input_to_uut   = in_q;
    assign done           = done_q;
    assign err            = err_q;
    assign vec_idx        = k_q;
endmodule
